// File: rtl/uart_cmd_framer_pkg.sv
// Shared state encodings and size helpers for the UART command framer.
package uart_cmd_framer_pkg;
  typedef enum logic [1:0] {RX_WAIT = 2'd0, RX_ACK = 2'd1, RX_FULL = 2'd2} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_HDR = 2'd1, TX_BYTE = 2'd2} tx_state_t;

  function automatic int pkt_bytes(input int op_bytes, input int n_ops);
    return 1 + n_ops * op_bytes;
  endfunction

  // Bits needed to hold values 0..n-1 (never less than 1).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_cmd_framer_tx.sv
// Result serialiser: latches a result (plus optional cmd header) and streams it MSB first.
module uart_cmd_framer_tx
  import uart_cmd_framer_pkg::*;
#(
  parameter int RES_BYTES = 4,
  parameter int RESP_HDR  = 0
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic [RES_BYTES*8-1:0] i_res_data,
  input  logic                   i_res_valid,
  output logic                   o_res_ready,
  input  logic [7:0]             i_cmd,
  output logic [7:0]             o_tx,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready
);
  localparam int TXB = RES_BYTES + RESP_HDR;
  localparam int TXW = 8 * TXB;
  localparam int BW  = cnt_w(TXB + 1);

  tx_state_t       r_st;
  logic [TXW-1:0]  r_sh;
  logic [BW-1:0]   r_left;
  logic            r_res_ready;
  logic            r_tx_valid;

  assign o_tx        = r_sh[TXW-1 -: 8];
  assign o_tx_valid  = r_tx_valid;
  assign o_res_ready = r_res_ready;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_st        <= TX_IDLE;
      r_sh        <= '0;
      r_left      <= '0;
      r_res_ready <= 1'b1;
      r_tx_valid  <= 1'b0;
    end else begin
      case (r_st)
        TX_IDLE: if (i_res_valid) begin
          // Cast drops the cmd byte when no header is configured.
          r_sh        <= TXW'({i_cmd, i_res_data});
          r_left      <= BW'(TXB);
          r_res_ready <= 1'b0;
          r_tx_valid  <= 1'b1;
          r_st        <= (RESP_HDR != 0) ? TX_HDR : TX_BYTE;
        end
        TX_HDR, TX_BYTE: if (i_tx_ready) begin
          r_sh   <= r_sh << 8;
          r_left <= r_left - 1'b1;
          r_st   <= TX_BYTE;
          if (r_left == BW'(1)) begin
            r_tx_valid  <= 1'b0;
            r_res_ready <= 1'b1;
            r_st        <= TX_IDLE;
          end
        end
        default: r_st <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_cmd_framer.sv
// Command framer: assembles cmd+operand packets from a 4-phase RX byte link and
// hands results to the TX serialiser; stalled partial packets are dropped on timeout.
module uart_cmd_framer
  import uart_cmd_framer_pkg::*;
#(
  parameter int OP_BYTES    = 4,
  parameter int N_OPS       = 2,
  parameter int RES_BYTES   = 4,
  parameter int RESP_HDR    = 0,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic [7:0]                  UART_RX,
  input  logic                        UART_RX_valid,
  output logic                        UART_RX_ack,
  output logic [7:0]                  PKT_CMD,
  output logic [N_OPS*OP_BYTES*8-1:0] PKT_OPS,
  output logic                        PKT_valid,
  input  logic                        PKT_ready,
  input  logic [RES_BYTES*8-1:0]      RES_DATA,
  input  logic                        RES_valid,
  output logic                        RES_ready,
  output logic [7:0]                  UART_TX,
  output logic                        UART_TX_valid,
  input  logic                        UART_TX_ready,
  output logic                        ERR_TIMEOUT
);
  localparam int PKT_BYTES = pkt_bytes(OP_BYTES, N_OPS);
  localparam int CW        = cnt_w(PKT_BYTES + 1);
  localparam int TW        = cnt_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_FULL = CW'(PKT_BYTES);
  localparam logic [TW-1:0] TLIM     = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  rx_state_t              r_rx_st;
  logic [CW-1:0]          r_cnt;
  logic [TW-1:0]          r_timer;
  logic [PKT_BYTES*8-1:0] r_pkt;
  logic                   r_ack;
  logic                   r_pkt_valid;
  logic                   r_err;
  logic [7:0]             r_last_cmd;
  logic                   w_tmo_run;
  logic                   w_expire;

  // Timer only runs while waiting on the sender between bytes of a partial packet.
  assign w_tmo_run = (TIMEOUT_CYC != 0) && (r_rx_st == RX_WAIT) && (r_cnt != '0);
  assign w_expire  = w_tmo_run && (r_timer == TLIM);

  assign UART_RX_ack = r_ack;
  assign PKT_CMD     = r_pkt[PKT_BYTES*8-1 -: 8];
  assign PKT_OPS     = r_pkt[N_OPS*OP_BYTES*8-1:0];
  assign PKT_valid   = r_pkt_valid;
  assign ERR_TIMEOUT = r_err;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_rx_st     <= RX_WAIT;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_pkt       <= '0;
      r_ack       <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_err       <= 1'b0;
      r_last_cmd  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_rx_st)
        RX_WAIT: begin
          // Expiry beats a coincident byte offer; that byte lands as index 0 next cycle.
          if (w_expire) begin
            r_cnt   <= '0;
            r_timer <= '0;
            r_err   <= 1'b1;
          end else if (UART_RX_valid) begin
            for (int i = 0; i < PKT_BYTES; i++)
              if (r_cnt == CW'(i)) r_pkt[8*(PKT_BYTES-1-i) +: 8] <= UART_RX;
            r_ack   <= 1'b1;
            r_timer <= '0;
            r_rx_st <= RX_ACK;
          end else if (w_tmo_run) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RX_ACK: if (!UART_RX_valid) begin
          r_ack <= 1'b0;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt + 1'b1 == CNT_FULL) begin
            r_pkt_valid <= 1'b1;
            r_rx_st     <= RX_FULL;
          end else begin
            r_rx_st <= RX_WAIT;
          end
        end
        RX_FULL: if (PKT_ready) begin
          r_pkt_valid <= 1'b0;
          r_cnt       <= '0;
          r_last_cmd  <= r_pkt[PKT_BYTES*8-1 -: 8];
          r_rx_st     <= RX_WAIT;
        end
        default: r_rx_st <= RX_WAIT;
      endcase
    end
  end

  uart_cmd_framer_tx #(.RES_BYTES(RES_BYTES), .RESP_HDR(RESP_HDR)) u_tx (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .i_res_data (RES_DATA),
    .i_res_valid(RES_valid),
    .o_res_ready(RES_ready),
    .i_cmd      (r_last_cmd),
    .o_tx       (UART_TX),
    .o_tx_valid (UART_TX_valid),
    .i_tx_ready (UART_TX_ready)
  );
endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench: two framer configurations, expected packets/bytes queued by stimulus, popped by monitors.
module tb_uart_cmd_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4-byte ops x2, 4-byte result, no header, short timeout
  logic [7:0]  a_rx = '0;
  logic        a_rx_valid = 1'b0, a_rx_ack;
  logic [7:0]  a_cmd;
  logic [63:0] a_ops;
  logic        a_pkt_valid, a_pkt_ready = 1'b1;
  logic [31:0] a_res = '0;
  logic        a_res_valid = 1'b0, a_res_ready;
  logic [7:0]  a_tx;
  logic        a_tx_valid, a_tx_ready = 1'b1, a_err;
  int          a_tx_mode = 0;

  // Instance B: 2-byte ops x3, 2-byte result, cmd header, timeout disabled
  logic [7:0]  b_rx = '0;
  logic        b_rx_valid = 1'b0, b_rx_ack;
  logic [7:0]  b_cmd;
  logic [47:0] b_ops;
  logic        b_pkt_valid, b_pkt_ready = 1'b1;
  logic [15:0] b_res = '0;
  logic        b_res_valid = 1'b0, b_res_ready;
  logic [7:0]  b_tx;
  logic        b_tx_valid, b_tx_ready = 1'b1, b_err;

  uart_cmd_framer #(.OP_BYTES(4), .N_OPS(2), .RES_BYTES(4), .RESP_HDR(0), .TIMEOUT_CYC(50)) dut_a (
    .CLK(clk), .RESETn(rst_n), .UART_RX(a_rx), .UART_RX_valid(a_rx_valid), .UART_RX_ack(a_rx_ack),
    .PKT_CMD(a_cmd), .PKT_OPS(a_ops), .PKT_valid(a_pkt_valid), .PKT_ready(a_pkt_ready),
    .RES_DATA(a_res), .RES_valid(a_res_valid), .RES_ready(a_res_ready),
    .UART_TX(a_tx), .UART_TX_valid(a_tx_valid), .UART_TX_ready(a_tx_ready), .ERR_TIMEOUT(a_err));

  uart_cmd_framer #(.OP_BYTES(2), .N_OPS(3), .RES_BYTES(2), .RESP_HDR(1), .TIMEOUT_CYC(0)) dut_b (
    .CLK(clk), .RESETn(rst_n), .UART_RX(b_rx), .UART_RX_valid(b_rx_valid), .UART_RX_ack(b_rx_ack),
    .PKT_CMD(b_cmd), .PKT_OPS(b_ops), .PKT_valid(b_pkt_valid), .PKT_ready(b_pkt_ready),
    .RES_DATA(b_res), .RES_valid(b_res_valid), .RES_ready(b_res_ready),
    .UART_TX(b_tx), .UART_TX_valid(b_tx_valid), .UART_TX_ready(b_tx_ready), .ERR_TIMEOUT(b_err));

  int n_cmp = 0;
  int n_bad = 0;
  int a_ack_rises = 0;

  logic [71:0] qa_pkt[$];
  logic [55:0] qb_pkt[$];
  logic [7:0]  qa_tx[$];
  logic [7:0]  qb_tx[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [127:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h want nothing queued", nm, act);
  endtask

  always @(posedge a_rx_ack) a_ack_rises++;

  // TX ready pattern for A: 0 = hold 1, 1 = toggle, other = hold 0
  always @(posedge clk) begin
    #1;
    case (a_tx_mode)
      0:       a_tx_ready = 1'b1;
      1:       a_tx_ready = ~a_tx_ready;
      default: a_tx_ready = 1'b0;
    endcase
  end

  // Monitors sample on the falling edge, away from DUT updates.
  logic       a_hold_pend = 1'b0;
  logic [7:0] a_hold_byte = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_hold_pend = 1'b0;
    end else begin
      if (a_hold_pend) chk("a_tx_hold", {a_tx_valid, a_tx}, {1'b1, a_hold_byte});
      a_hold_pend = a_tx_valid && !a_tx_ready;
      a_hold_byte = a_tx;
      if (a_tx_valid && a_tx_ready) begin
        if (qa_tx.size() == 0) unexpected("a_tx_byte", a_tx);
        else chk("a_tx_byte", a_tx, qa_tx.pop_front());
      end
      if (a_pkt_valid && a_pkt_ready) begin
        if (qa_pkt.size() == 0) unexpected("a_pkt", {a_cmd, a_ops});
        else chk("a_pkt", {a_cmd, a_ops}, qa_pkt.pop_front());
      end
      if (b_tx_valid && b_tx_ready) begin
        if (qb_tx.size() == 0) unexpected("b_tx_byte", b_tx);
        else chk("b_tx_byte", b_tx, qb_tx.pop_front());
      end
      if (b_pkt_valid && b_pkt_ready) begin
        if (qb_pkt.size() == 0) unexpected("b_pkt", {b_cmd, b_ops});
        else chk("b_pkt", {b_cmd, b_ops}, qb_pkt.pop_front());
      end
    end
  end

  function automatic logic rx_ack(input int w);
    return (w == 0) ? a_rx_ack : b_rx_ack;
  endfunction

  // One 4-phase byte transfer, bounded on both handshake edges.
  task automatic send(input int w, input logic [7:0] b);
    int n;
    if (w == 0) begin a_rx = b; a_rx_valid = 1'b1; end
    else begin b_rx = b; b_rx_valid = 1'b1; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rx_ack(w) == 1'b0 && n < 200);
    if (rx_ack(w) == 1'b0) unexpected("rx_ack_rise_timeout", b);
    if (w == 0) a_rx_valid = 1'b0; else b_rx_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rx_ack(w) == 1'b1 && n < 200);
    if (rx_ack(w) == 1'b1) unexpected("rx_ack_fall_timeout", b);
  endtask

  task automatic send_word(input int w, input logic [63:0] v, input int nb);
    logic [63:0] t;
    t = v << (8 * (8 - nb));
    for (int i = 0; i < nb; i++) begin
      send(w, t[63:56]);
      t = t << 8;
    end
  endtask

  task automatic send_res(input int w, input logic [31:0] r);
    int n;
    if (w == 0) begin a_res = r; a_res_valid = 1'b1; end
    else begin b_res = r[15:0]; b_res_valid = 1'b1; end
    @(posedge clk); #1;
    a_res_valid = 1'b0;
    b_res_valid = 1'b0;
    n = 0;
    while (((w == 0) ? a_res_ready : b_res_ready) == 1'b0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) unexpected("res_ready_timeout", r);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_ctrl"}, {a_rx_ack, a_pkt_valid, a_res_ready, a_tx_valid, a_err}, 5'b00100);
    chk({tag, "_a_pkt"}, {a_cmd, a_ops}, 72'h0);
    chk({tag, "_a_tx"}, a_tx, 8'h00);
    chk({tag, "_b_ctrl"}, {b_rx_ack, b_pkt_valid, b_res_ready, b_tx_valid, b_err}, 5'b00100);
  endtask

  initial begin
    int  n;
    logic acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 'd',14,2 -> packet on the cycle after the last valid fall
    a_ack_rises = 0;
    qa_pkt.push_back({8'h64, 64'h0000000E_00000002});
    send(0, 8'h64);
    send_word(0, 64'h0000000E_00000002, 8);
    chk("a_pkt_latency", a_pkt_valid, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("a_ack_count", a_ack_rises, 9);

    // Backpressure: full packet held, extra byte not acked until it is taken
    a_pkt_ready = 1'b0;
    qa_pkt.push_back({8'h41, 64'h11223344_55667788});
    send(0, 8'h41);
    send_word(0, 64'h11223344_55667788, 8);
    a_rx = 8'h6D; a_rx_valid = 1'b1;
    acc = 1'b0;
    repeat (6) begin @(posedge clk); #1; acc = acc | a_rx_ack; end
    chk("a_bp_no_ack", acc, 1'b0);
    chk("a_bp_pkt_stable", {a_pkt_valid, a_cmd, a_ops}, {1'b1, 8'h41, 64'h11223344_55667788});
    a_pkt_ready = 1'b1;
    qa_pkt.push_back({8'h6D, 64'hCAFEBABE_00000001});
    send(0, 8'h6D);
    send_word(0, 64'hCAFEBABE_00000001, 8);
    repeat (2) @(posedge clk); #1;

    // Timeout: 5 bytes then silence
    for (int i = 0; i < 5; i++) send(0, 8'h72);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (a_err == 1'b0 && n < 200);
    chk("a_timeout_cycles", n, 50);
    @(posedge clk); #1;
    chk("a_err_pulse_width", a_err, 1'b0);
    qa_pkt.push_back({8'h63, 64'h01020304_05060708});
    send(0, 8'h63);
    send_word(0, 64'h01020304_05060708, 8);
    repeat (2) @(posedge clk); #1;

    // TX with ready toggling, then with ready held high
    a_tx_mode = 2;
    @(posedge clk); #1;
    a_tx_mode = 1;
    qa_tx.push_back(8'hFF); qa_tx.push_back(8'hFF); qa_tx.push_back(8'hFF); qa_tx.push_back(8'hFE);
    send_res(0, 32'hFFFFFFFE);
    chk("a_tx_q_drained1", qa_tx.size(), 0);
    a_tx_mode = 0;
    @(posedge clk); #1;
    qa_tx.push_back(8'h12); qa_tx.push_back(8'h34); qa_tx.push_back(8'h56); qa_tx.push_back(8'h78);
    send_res(0, 32'h12345678);
    chk("a_tx_q_drained2", qa_tx.size(), 0);

    // Instance B: header echo of the last accepted cmd
    qb_pkt.push_back({8'h48, 48'h0001_0002_0003});
    send(1, 8'h48);
    send_word(1, 64'h0000_0001_0002_0003, 6);
    repeat (2) @(posedge clk); #1;
    qb_tx.push_back(8'h48); qb_tx.push_back(8'h12); qb_tx.push_back(8'h34);
    send_res(1, 32'h0000_1234);
    chk("b_tx_q_drained", qb_tx.size(), 0);

    // Reset mid-packet and mid-TX
    send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC);
    a_tx_mode = 2;
    a_res = 32'hAABBCCDD; a_res_valid = 1'b1;
    @(posedge clk); #1;
    a_res_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("a_tx_stalled", a_tx_valid, 1'b1);
    rst_n = 1'b0;
    a_tx_mode = 0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    qa_pkt.push_back({8'h5A, 64'h0BADF00D_DEADBEEF});
    send(0, 8'h5A);
    send_word(0, 64'h0BADF00D_DEADBEEF, 8);
    repeat (4) @(posedge clk); #1;

    chk("a_pkt_q_empty", qa_pkt.size(), 0);
    chk("b_pkt_q_empty", qb_pkt.size(), 0);
    chk("a_tx_q_empty", qa_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
